// File: rtl/rc5_key_schedule_ctrl_pkg.sv
// RC5-32 key schedule shared constants, state codes and helpers.
// Imported by the sequencer and its mixing datapath.
package rc5_key_schedule_ctrl_pkg;

  localparam int W   = 32;
  localparam int B   = 16;
  localparam int T   = 26;
  localparam int C   = 4;
  localparam int LGW = 5;
  localparam int MIX_CNT = 3 * ((T > C) ? T : C);

  localparam int AW = 5;
  localparam int JW = 2;
  localparam int CW = 7;

  localparam logic [W-1:0] P32 = 32'hB7E15163;
  localparam logic [W-1:0] Q32 = 32'h9E3779B9;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_INIT = 3'd2;
  localparam logic [2:0] ST_MIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [AW-1:0] I_LAST = AW'(T - 1);
  localparam logic [AW-1:0] T_END  = AW'(T);
  localparam logic [JW-1:0] J_LAST = JW'(C - 1);
  localparam logic [CW-1:0] INIT_LAST = CW'(T - 1);
  localparam logic [CW-1:0] MIX_LAST  = CW'(MIX_CNT - 1);

  typedef logic [W-1:0] word_t;

  typedef struct packed {
    word_t a;
    word_t b;
  } mix_ab_t;

  // Rotate left: top half of the doubled word shifted by n.
  function automatic word_t rotl(input word_t x,
                                 input logic [LGW-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} << n;
    return t[2*W-1:W];
  endfunction

endpackage

// File: rtl/rc5_mix_unit.sv
// One RC5 key-mixing step: new A from S[i], new B from L[j].
// Purely combinational; the sequencer registers the results.
module rc5_mix_unit
  import rc5_key_schedule_ctrl_pkg::*;
(
  input  logic [W-1:0] s_i,
  input  logic [W-1:0] l_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output mix_ab_t      ab_o
);

  word_t a_n;
  word_t ab_sum;

  always_comb begin
    a_n    = rotl(s_i + a_i + b_i, LGW'(3));
    ab_sum = a_n + b_i;
    ab_o.a = a_n;
    ab_o.b = rotl(l_i + ab_sum, ab_sum[LGW-1:0]);
  end

endmodule

// File: rtl/rc5_key_schedule_ctrl.sv
// RC5-32 key expansion sequencer: load L, init S, mix, expose S.
// S/L register files plus a registered S read port.
module rc5_key_schedule_ctrl
  import rc5_key_schedule_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   pW,
  input  logic [W-1:0]   qW,
  input  logic [8*B-1:0] key,
  output logic           busy,
  output logic           done,
  output logic           key_valid,
  input  logic [AW-1:0]  rd_addr,
  output logic [W-1:0]   rd_data
);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          kv_q, kv_d;
  logic [W-1:0]  rd_q, rd_d;

  logic [W-1:0]   p_q;
  logic [W-1:0]   q_q;
  logic [8*B-1:0] key_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [AW-1:0]  i_q;
  logic [JW-1:0]  j_q;
  logic [W-1:0]   s_q [T];
  logic [W-1:0]   l_q [C];

  logic [AW-1:0] init_idx;
  logic [AW-1:0] init_prev;
  logic          accept;
  mix_ab_t       mix;

  assign init_idx  = cnt_q[AW-1:0];
  assign init_prev = init_idx - AW'(1);
  assign accept    = (state_q == ST_IDLE) && start;

  rc5_mix_unit u_mix (
    .s_i  (s_q[i_q]),
    .l_i  (l_q[j_q]),
    .a_i  (a_q),
    .b_i  (b_q),
    .ab_o (mix)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kv_d    = kv_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          kv_d    = 1'b0;
        end
      end
      ST_LOAD: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
      ST_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = ST_MIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_MIX: begin
        // Raise key_valid on entry so it coincides with done.
        if (cnt_q == MIX_LAST) begin
          state_d = ST_DONE;
          kv_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_d = '0;
    if (rd_addr < T_END) rd_d = s_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      kv_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kv_q    <= kv_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      p_q   <= pW;
      q_q   <= qW;
      key_q <= key;
    end
    if (state_q == ST_LOAD) begin
      for (int k = 0; k < C; k++) begin
        l_q[k] <= key_q[W*k +: W];
      end
      a_q <= '0;
      b_q <= '0;
      i_q <= '0;
      j_q <= '0;
    end
    if (state_q == ST_INIT) begin
      if (init_idx == '0) s_q[init_idx] <= p_q;
      else s_q[init_idx] <= s_q[init_prev] + q_q;
    end
    if (state_q == ST_MIX) begin
      s_q[i_q] <= mix.a;
      l_q[j_q] <= mix.b;
      a_q <= mix.a;
      b_q <= mix.b;
      i_q <= (i_q == I_LAST) ? '0 : i_q + AW'(1);
      j_q <= (j_q == J_LAST) ? '0 : j_q + JW'(1);
    end
  end

  assign busy = (state_q == ST_LOAD) ||
                (state_q == ST_INIT) ||
                (state_q == ST_MIX);
  assign done      = (state_q == ST_DONE);
  assign key_valid = kv_q;
  assign rd_data   = rd_q;

endmodule
